// File: rtl/lpif_ll_pkg.sv
// Shared definitions for the LPIF logic-link receive buffer and its credit path:
// debug status field positions, the packed status word layout, and the
// occupancy-counter width helper.
package lpif_ll_pkg;

  // Bit positions of the fields inside the 32-bit debug status word.
  localparam int DBG_LEVEL_LSB  = 24;
  localparam int DBG_LEVEL_W    = 8;
  localparam int DBG_OVF_BIT    = 23;
  localparam int DBG_ONLINE_BIT = 22;
  localparam int DBG_FULL_BIT   = 21;
  localparam int DBG_EMPTY_BIT  = 20;
  localparam int DBG_RSVD_W     = 12;
  localparam int DBG_ACC_LSB    = 0;
  localparam int DBG_ACC_W      = 8;

  // Packed view of the debug status word, MSB first.
  typedef struct packed {
    logic [DBG_LEVEL_W-1:0] level;
    logic                   ovf;
    logic                   online;
    logic                   full;
    logic                   empty;
    logic [DBG_RSVD_W-1:0]  rsvd;
    logic [DBG_ACC_W-1:0]   acc;
  } lpif_ll_dbg_status_t;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lpif_ll_credit_coalesce.sv
// Credit coalescer: increments accumulate in acc; whenever the output register
// is free (empty or completing a handshake) any pending credits move into it
// as one value presented with valid/ready. clr_i drops everything.
module lpif_ll_credit_coalesce
  import lpif_ll_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic                ready_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                valid_o,
  output logic [CREDIT_W-1:0] acc_o
);

  logic [CREDIT_W-1:0] acc_q, acc_d;
  logic [CREDIT_W-1:0] out_q, out_d;
  logic [CREDIT_W-1:0] sum_s;
  logic                out_free_s;
  logic                load_s;

  // Next-state for the accumulator / output pair; out is only replaced when free.
  always_comb begin
    sum_s      = acc_q + CREDIT_W'(inc_i);
    out_free_s = (out_q == '0) || ready_i;
    load_s     = out_free_s && (sum_s != '0);
    acc_d      = acc_q;
    out_d      = out_q;
    if (clr_i) begin
      acc_d = '0;
      out_d = '0;
    end else if (load_s) begin
      out_d = sum_s;
      acc_d = '0;
    end else begin
      acc_d = sum_s;
      if (out_free_s) begin
        out_d = '0;
      end else begin
        out_d = out_q;
      end
    end
  end

  // Credit state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign credit_o = out_q;
  assign valid_o  = (out_q != '0);
  assign acc_o    = acc_q;

endmodule

// File: rtl/lpif_ll_rx_credit_buf.sv
// Receive-side logic-link buffer: first-word-fall-through FIFO gated by the
// registered online flag, sticky overflow detection, flush on loss of online,
// and a coalesced credit-return channel (one credit per popped beat).
// Optional macro LPIF_LL_RX_DEBUG_STATUS_EN drives debug_status with a packed
// status word; without it debug_status is constant zero.
module lpif_ll_rx_credit_buf
  import lpif_ll_pkg::*;
#(
  parameter int DATA_W   = 290,
  parameter int DEPTH    = 16,
  parameter int CREDIT_W = 8
) (
  input  logic                         clk_wr,
  input  logic                         rst_wr,
  input  logic                         rx_online,
  input  logic                         rx_push,
  input  logic [DATA_W-1:0]            rx_push_data,
  output logic [DATA_W-1:0]            usr_data,
  output logic                         usr_valid,
  input  logic                         usr_ready,
  output logic [CREDIT_W-1:0]          credit_ret,
  output logic                         credit_ret_valid,
  input  logic                         credit_ret_ready,
  output logic [lvl_width(DEPTH)-1:0]  fifo_level,
  output logic                         overflow_err,
  output logic [31:0]                  debug_status
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_width(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ovf_q, ovf_d;
  logic                rx_online_q;
  logic                flush_q;

  logic                full_s;
  logic                empty_s;
  logic                pop_s;
  logic                push_s;
  logic                drop_s;
  logic [CREDIT_W-1:0] credit_acc_s;

  assign full_s  = (level_q == DEPTH_LVL);
  assign empty_s = (level_q == '0);

  // Handshake decode: pops need a visible head; a full FIFO still accepts a push when it pops.
  always_comb begin
    usr_valid = !empty_s && rx_online_q;
    pop_s     = usr_valid && usr_ready;
    push_s    = rx_push && rx_online_q && (!full_s || pop_s);
    drop_s    = rx_push && rx_online_q && full_s && !pop_s;
  end

  // Pointer, level and overflow next-state; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (flush_q) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      ovf_d = ovf_q || drop_s;
    end
  end

  // Control registers; a falling online edge schedules a flush for the next cycle.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      rx_online_q <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      rx_online_q <= rx_online;
      flush_q     <= rx_online_q && !rx_online;
    end
  end

  // Payload storage; data is only meaningful where the level says so, so no reset.
  always_ff @(posedge clk_wr) begin
    if (push_s && !flush_q) begin
      mem_q[wr_ptr_q] <= rx_push_data;
    end
  end

  assign usr_data     = empty_s ? '0 : mem_q[rd_ptr_q];
  assign fifo_level   = level_q;
  assign overflow_err = ovf_q;

  lpif_ll_credit_coalesce #(
    .CREDIT_W (CREDIT_W)
  ) u_credit (
    .clk_i    (clk_wr),
    .rst_i    (rst_wr),
    .clr_i    (flush_q),
    .inc_i    (pop_s),
    .ready_i  (credit_ret_ready),
    .credit_o (credit_ret),
    .valid_o  (credit_ret_valid),
    .acc_o    (credit_acc_s)
  );

`ifdef LPIF_LL_RX_DEBUG_STATUS_EN
  lpif_ll_dbg_status_t dbg_s;

  // Pack live FIFO and credit state into the status word.
  always_comb begin
    dbg_s        = '0;
    dbg_s.level  = DBG_LEVEL_W'(level_q);
    dbg_s.ovf    = ovf_q;
    dbg_s.online = rx_online_q;
    dbg_s.full   = full_s;
    dbg_s.empty  = empty_s;
    dbg_s.rsvd   = '0;
    dbg_s.acc    = DBG_ACC_W'(credit_acc_s);
  end

  assign debug_status = dbg_s;
`else
  logic unused_acc_s;
  assign unused_acc_s = ^credit_acc_s;
  assign debug_status = 32'h0;
`endif

endmodule

// File: tb/tb_lpif_ll_rx_credit_buf.sv
// Directed bench for lpif_ll_rx_credit_buf: a vector table for basic
// streaming and credit return, plus hand-written overflow, full-bypass,
// credit-hold and flush sequences.
module tb_lpif_ll_rx_credit_buf;

  localparam int DATA_W   = 290;
  localparam int DEPTH    = 16;
  localparam int CREDIT_W = 8;
  localparam int LVL_W    = 5;

  logic                clk_wr = 1'b0;
  logic                rst_wr;
  logic                rx_online;
  logic                rx_push;
  logic [DATA_W-1:0]   rx_push_data;
  logic [DATA_W-1:0]   usr_data;
  logic                usr_valid;
  logic                usr_ready;
  logic [CREDIT_W-1:0] credit_ret;
  logic                credit_ret_valid;
  logic                credit_ret_ready;
  logic [LVL_W-1:0]    fifo_level;
  logic                overflow_err;
  logic [31:0]         debug_status;

  int errors = 0;
  int checks = 0;
  int cred_total = 0;

  lpif_ll_rx_credit_buf #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .CREDIT_W (CREDIT_W)
  ) dut (
    .clk_wr           (clk_wr),
    .rst_wr           (rst_wr),
    .rx_online        (rx_online),
    .rx_push          (rx_push),
    .rx_push_data     (rx_push_data),
    .usr_data         (usr_data),
    .usr_valid        (usr_valid),
    .usr_ready        (usr_ready),
    .credit_ret       (credit_ret),
    .credit_ret_valid (credit_ret_valid),
    .credit_ret_ready (credit_ret_ready),
    .fifo_level       (fifo_level),
    .overflow_err     (overflow_err),
    .debug_status     (debug_status)
  );

  always #5 clk_wr = ~clk_wr;

  // Sum of credit values handed over on completed handshakes.
  always @(posedge clk_wr) begin
    if (!rst_wr && credit_ret_valid && credit_ret_ready) begin
      cred_total = cred_total + int'(credit_ret);
    end
  end

  typedef struct {
    logic        on;
    logic        push;
    int unsigned tag;
    logic        ur;
    logic        cr;
    logic        ev;
    int          elvl;
    int unsigned etag;
    logic        eovf;
    logic        ecv;
    int          ecr;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [DATA_W-1:0] mk(input int unsigned tag);
    logic [31:0] t;
    t = tag;
    if (tag == 0) return '0;
    return {2'b10, {9{t}}};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic on, input logic push, input int unsigned tag, input logic ur, input logic cr);
    rx_online        = on;
    rx_push          = push;
    rx_push_data     = mk(tag);
    usr_ready        = ur;
    credit_ret_ready = cr;
    @(posedge clk_wr);
    #1;
  endtask

  task automatic check_state(input string name, input logic ev, input int elvl, input int unsigned etag,
                             input logic eovf, input logic ecv, input int ecr);
    chk({name, ".usr_valid"}, usr_valid, ev);
    chk({name, ".fifo_level"}, fifo_level, elvl);
    chk({name, ".usr_data"}, usr_data, mk(etag));
    chk({name, ".overflow_err"}, overflow_err, eovf);
    chk({name, ".credit_ret_valid"}, credit_ret_valid, ecv);
    chk({name, ".credit_ret"}, credit_ret, ecr);
`ifdef LPIF_LL_RX_DEBUG_STATUS_EN
    chk({name, ".dbg_level"}, debug_status[31:24], elvl);
    chk({name, ".dbg_ovf"}, debug_status[23], eovf);
`else
    chk({name, ".debug_status"}, debug_status, 32'h0);
`endif
  endtask

  task automatic do_reset();
    rst_wr = 1'b1;
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    rst_wr = 1'b0;
    cred_total = 0;
  endtask

  initial begin
    rst_wr = 1'b1;
    rx_online = 1'b0; rx_push = 1'b0; rx_push_data = '0;
    usr_ready = 1'b0; credit_ret_ready = 1'b0;

    //                on    push  tag   ur    cr    ev    lvl tag   ovf   cv    cr
    tbl[0] = '{1'b1, 1'b0, 0,    1'b0, 1'b0, 1'b0, 0,  0,    1'b0, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b1, 'hA,  1'b1, 1'b0, 1'b1, 1,  'hA,  1'b0, 1'b0, 0};
    tbl[2] = '{1'b1, 1'b1, 'hB,  1'b1, 1'b0, 1'b1, 1,  'hB,  1'b0, 1'b1, 1};
    tbl[3] = '{1'b1, 1'b1, 'hC,  1'b1, 1'b0, 1'b1, 1,  'hC,  1'b0, 1'b1, 1};
    tbl[4] = '{1'b1, 1'b0, 0,    1'b1, 1'b0, 1'b0, 0,  0,    1'b0, 1'b1, 1};
    tbl[5] = '{1'b1, 1'b0, 0,    1'b0, 1'b1, 1'b0, 0,  0,    1'b0, 1'b1, 2};
    tbl[6] = '{1'b1, 1'b0, 0,    1'b0, 1'b1, 1'b0, 0,  0,    1'b0, 1'b0, 0};

    // Reset state
    do_reset();
    check_state("reset", 1'b0, 0, 0, 1'b0, 1'b0, 0);

    // Streaming A, B, C and credit return
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].on, tbl[i].push, tbl[i].tag, tbl[i].ur, tbl[i].cr);
      check_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].elvl, tbl[i].etag,
                  tbl[i].eovf, tbl[i].ecv, tbl[i].ecr);
    end
    chk("abc.cred_total", 32'(cred_total), 32'd3);

    // Fill to 16, 17th beat dropped, then drain in order
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 1'b1, i, 1'b0, 1'b0);
      check_state($sformatf("fill%0d", i), 1'b1, (i > 16) ? 16 : i, 1, (i > 16), 1'b0, 0);
    end
`ifdef LPIF_LL_RX_DEBUG_STATUS_EN
    chk("ovf.dbg_hi", debug_status[31:20], 12'h10E);
`endif
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain%0d.usr_data", i), usr_data, mk(i));
      step(1'b1, 1'b0, 0, 1'b1, 1'b0);
    end
    check_state("drained", 1'b0, 0, 0, 1'b1, 1'b1, 1);
    // Dropping online flushes and clears the sticky overflow
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check_state("ovf_flush", 1'b0, 0, 0, 1'b0, 1'b0, 0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, i, 1'b0, 1'b0);
    check_state("full", 1'b1, 16, 1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 50, 1'b1, 1'b0);
    check_state("full_pp", 1'b1, 16, 2, 1'b0, 1'b1, 1);

    // Credit held while not ready, coalesced value on handshake
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, i, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 0, 1'b1, 1'b0);
      check_state($sformatf("hold%0d", i), (i < 5), 5 - i, (i < 5) ? i + 1 : 0, 1'b0, 1'b1, 1);
    end
`ifdef LPIF_LL_RX_DEBUG_STATUS_EN
    chk("hold.dbg_acc", debug_status[7:0], 8'd4);
`endif
    step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    check_state("coalesce", 1'b0, 0, 0, 1'b0, 1'b1, 4);
    step(1'b1, 1'b0, 0, 1'b0, 1'b1);
    check_state("coalesce_done", 1'b0, 0, 0, 1'b0, 1'b0, 0);
    chk("hold.cred_total", 32'(cred_total), 32'd5);

    // Mid-stream online loss with level 7
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, i, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b1, 1'b0);
    check_state("pre_fall", 1'b1, 7, 2, 1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    check_state("fall_n1", 1'b0, 7, 2, 1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 99, 1'b1, 1'b0);
    check_state("fall_n2", 1'b0, 0, 0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 98, 1'b0, 1'b0);
    check_state("offline_push", 1'b0, 0, 0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 97, 1'b0, 1'b0);
    check_state("rise_push", 1'b0, 0, 0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 5, 1'b0, 1'b0);
    check_state("online_push", 1'b1, 1, 5, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
